// File: rtl/audio_pkg.sv
// Shared audio sample/frame types used by the codec driver, capture path and frame FIFO.
// Channel index constants fix the left/right ordering inside a stereo frame.
package audio_pkg;

  typedef logic [15:0] t_sample;
  typedef t_sample [1:0] t_frame;

  localparam int AUDIO_CH_L = 0;
  localparam int AUDIO_CH_R = 1;

  function automatic t_frame mk_frame(
    input t_sample l,
    input t_sample r
  );
    t_frame f;
    f[AUDIO_CH_L] = l;
    f[AUDIO_CH_R] = r;
    return f;
  endfunction

endpackage

// File: rtl/audio_frame_fifo_if.sv
// Producer/driver side bundle of the audio frame FIFO.
// master = source + codec driver, slave = the FIFO itself.
interface audio_frame_fifo_if #(
  parameter int p_depth = 16,
  parameter int p_width = 16
);

  logic [1:0][p_width-1:0]   i_wr_dat;
  logic                      i_wr_vld;
  logic                      o_wr_rdy;
  logic                      i_ack;
  logic [1:0][p_width-1:0]   o_dat;
  logic                      i_flush;
  logic [$clog2(p_depth):0]  o_level;
  logic                      o_underrun;
  logic [15:0]               o_urun_cnt;

  modport master (
    output i_wr_dat, i_wr_vld, i_ack, i_flush,
    input  o_wr_rdy, o_dat, o_level,
    input  o_underrun, o_urun_cnt
  );

  modport slave (
    input  i_wr_dat, i_wr_vld, i_ack, i_flush,
    output o_wr_rdy, o_dat, o_level,
    output o_underrun, o_urun_cnt
  );

endinterface

// File: rtl/ram_sdp.sv
// Simple dual-port frame memory, registered read, write-first forwarding
// so a read of the address being written returns the new data.
module ram_sdp #(
  parameter int p_aw = 4,
  parameter int p_dw = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [p_aw-1:0] waddr,
  input  logic [p_dw-1:0] wdata,
  input  logic [p_aw-1:0] raddr,
  output logic [p_dw-1:0] rdata
);

  logic [p_dw-1:0] mem [0:(1<<p_aw)-1];

  // storage write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read with same-address forwarding
  always_ff @(posedge clk) begin
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_frame_fifo.sv
// Stereo frame FIFO feeding the WM8731 driver; pops on each driver ack.
// Define AUDIO_FIFO_UNDERRUN_HOLD_EN to repeat the last frame on underrun instead of muting.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int p_depth = 16,
  parameter int p_width = 16
) (
  input logic              i_clk,
  input logic              i_rst,
  audio_frame_fifo_if.slave bus
);

  localparam int AW = $clog2(p_depth);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH = LW'(p_depth);

  typedef logic [1:0][p_width-1:0] frame_t;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW-1:0] wr_nxt;
  logic [LW-1:0] level;
  logic [LW-1:0] lvl_nxt;
  logic          wr_rdy;
  logic          push;
  logic          pop;
  logic          urun;
  logic          urun_q;
  logic [15:0]   cnt_q;
  frame_t        head;
  frame_t        dat_q;
  frame_t        urun_dat;

  // head-of-queue prefetch: rdata always mirrors mem[rd_ptr]
  ram_sdp #(
    .p_aw (AW),
    .p_dw (2*p_width)
  ) u_ram (
    .clk   (i_clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.i_wr_dat),
    .raddr (rd_nxt),
    .rdata (head)
  );

  // flush wins over push/pop; an ack that cannot pop is an underrun
  always_comb begin
    push    = bus.i_wr_vld & wr_rdy & ~bus.i_flush;
    pop     = bus.i_ack & (level != '0) & ~bus.i_flush;
    urun    = bus.i_ack & ~pop;
    rd_nxt  = rd_ptr;
    wr_nxt  = wr_ptr;
    lvl_nxt = level;
    unique case (1'b1)
      bus.i_flush: begin
        rd_nxt  = '0;
        wr_nxt  = '0;
        lvl_nxt = '0;
      end
      push & pop: begin
        rd_nxt = rd_ptr + AW'(1);
        wr_nxt = wr_ptr + AW'(1);
      end
      push & ~pop: begin
        wr_nxt  = wr_ptr + AW'(1);
        lvl_nxt = level + LW'(1);
      end
      pop & ~push: begin
        rd_nxt  = rd_ptr + AW'(1);
        lvl_nxt = level - LW'(1);
      end
      default: ;
    endcase
`ifdef AUDIO_FIFO_UNDERRUN_HOLD_EN
    urun_dat = dat_q;
`else
    urun_dat = '0;
`endif
  end

  // pointers, level, presented frame and underrun bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      wr_rdy <= 1'b0;
      dat_q  <= '0;
      urun_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      level  <= lvl_nxt;
      wr_rdy <= lvl_nxt < DEPTH;
      urun_q <= urun;
      if (pop)       dat_q <= head;
      else if (urun) dat_q <= urun_dat;
      if (urun && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.o_wr_rdy   = wr_rdy;
  assign bus.o_dat      = dat_q;
  assign bus.o_level    = level;
  assign bus.o_underrun = urun_q;
  assign bus.o_urun_cnt = cnt_q;

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Scoreboard bench for audio_frame_fifo: directed cases plus random traffic
// against a queue-based frame model. Honours AUDIO_FIFO_UNDERRUN_HOLD_EN.
module tb_audio_frame_fifo;
  import audio_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  audio_frame_fifo_if #(.p_depth(DEPTH), .p_width(16)) bus ();

  audio_frame_fifo #(.p_depth(DEPTH), .p_width(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    t_frame      dat;
    logic        urun;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  t_frame      mq[$];
  t_frame      m_dat;
  logic [15:0] m_cnt;
  bit          m_rdy;
  bit          ack_seen;
  bit          acc;

  // reference model: frames in a queue, one pop per ack, sampled at the edge
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_dat    = '0;
      m_cnt    = '0;
      m_rdy    = 1'b0;
      ack_seen = 1'b0;
    end else begin
      acc      = bus.i_wr_vld && m_rdy && !bus.i_flush;
      ack_seen = bus.i_ack;
      if (bus.i_ack) begin
        if (bus.i_flush || mq.size() == 0) begin
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`ifndef AUDIO_FIFO_UNDERRUN_HOLD_EN
          m_dat = '0;
`endif
          exp_q.push_back('{m_dat, 1'b1, m_cnt});
        end else begin
          m_dat = mq.pop_front();
          exp_q.push_back('{m_dat, 1'b0, m_cnt});
        end
      end
      if (bus.i_flush) mq.delete();
      if (acc) mq.push_back(bus.i_wr_dat);
      m_rdy = mq.size() < DEPTH;
    end
  end

  // monitor: compare DUT outputs just after every edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      chk("level", 64'(bus.o_level), 64'(mq.size()));
      chk("wr_rdy", 64'(bus.o_wr_rdy), 64'(m_rdy));
      chk("urun_cnt", 64'(bus.o_urun_cnt), 64'(m_cnt));
      if (ack_seen) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_nonempty", 64'(0), 64'(1));
        end else begin
          e = exp_q.pop_front();
          chk("ack_dat", 64'(bus.o_dat), 64'(e.dat));
          chk("ack_urun", 64'(bus.o_underrun), 64'(e.urun));
        end
      end else begin
        chk("urun_idle", 64'(bus.o_underrun), 64'(0));
      end
    end
  end

  task automatic drive(bit vld, t_frame d, bit ack, bit fl);
    @(negedge clk);
    bus.i_wr_vld = vld;
    bus.i_wr_dat = d;
    bus.i_ack    = ack;
    bus.i_flush  = fl;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  t_frame z;
  t_frame hold_exp;
  t_frame fy;

  initial begin
    z = '0;
    bus.i_wr_vld = 1'b0;
    bus.i_wr_dat = '0;
    bus.i_ack    = 1'b0;
    bus.i_flush  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(bus.o_wr_rdy), 64'(0));
    chk("rst_level", 64'(bus.o_level), 64'(0));
    rst = 1'b0;
    settle();
    chk("idle_dat", 64'(bus.o_dat), 64'(0));
    chk("idle_level", 64'(bus.o_level), 64'(0));
    chk("idle_rdy", 64'(bus.o_wr_rdy), 64'(1));
    chk("idle_cnt", 64'(bus.o_urun_cnt), 64'(0));

    // two frames then two acks
    drive(1, mk_frame(16'h1111, 16'h2222), 0, 0);
    drive(1, mk_frame(16'h3333, 16'h4444), 0, 0);
    drive(0, z, 0, 0);
    settle();
    chk("two_level", 64'(bus.o_level), 64'(2));
    drive(0, z, 1, 0);
    settle();
    chk("ack1_dat", 64'(bus.o_dat), 64'(mk_frame(16'h1111, 16'h2222)));
    chk("ack1_level", 64'(bus.o_level), 64'(1));
    drive(0, z, 1, 0);
    settle();
    chk("ack2_dat", 64'(bus.o_dat), 64'(mk_frame(16'h3333, 16'h4444)));
    chk("ack2_level", 64'(bus.o_level), 64'(0));

    // ack on empty FIFO
    drive(0, z, 1, 0);
    settle();
`ifdef AUDIO_FIFO_UNDERRUN_HOLD_EN
    hold_exp = mk_frame(16'h3333, 16'h4444);
`else
    hold_exp = '0;
`endif
    chk("urun_pulse", 64'(bus.o_underrun), 64'(1));
    chk("urun_cnt1", 64'(bus.o_urun_cnt), 64'(1));
    chk("urun_dat", 64'(bus.o_dat), 64'(hold_exp));
    drive(0, z, 0, 0);
    settle();
    chk("urun_clear", 64'(bus.o_underrun), 64'(0));

    // fill with valid held for 17 frames
    for (int i = 0; i < 17; i++)
      drive(1, mk_frame(16'(i), 16'(~i)), 0, 0);
    drive(0, z, 0, 0);
    settle();
    chk("full_level", 64'(bus.o_level), 64'(16));
    chk("full_rdy", 64'(bus.o_wr_rdy), 64'(0));
    drive(1, mk_frame(16'hDEAD, 16'hBEEF), 1, 0);
    settle();
    chk("full_ack_level", 64'(bus.o_level), 64'(15));
    fy = mk_frame(16'h5A5A, 16'hA5A5);
    drive(1, fy, 1, 0);
    settle();
    chk("pushpop_level", 64'(bus.o_level), 64'(15));
    for (int i = 0; i < 15; i++) drive(0, z, 1, 0);
    drive(0, z, 0, 0);
    settle();
    chk("drain_last", 64'(bus.o_dat), 64'(fy));
    chk("drain_level", 64'(bus.o_level), 64'(0));

    // flush with ack at level 5
    for (int i = 0; i < 5; i++)
      drive(1, mk_frame(16'(100 + i), 16'(200 + i)), 0, 0);
    drive(0, z, 0, 0);
    settle();
    chk("lvl5", 64'(bus.o_level), 64'(5));
`ifdef AUDIO_FIFO_UNDERRUN_HOLD_EN
    hold_exp = fy;
`else
    hold_exp = '0;
`endif
    drive(0, z, 1, 1);
    settle();
    chk("flush_level", 64'(bus.o_level), 64'(0));
    chk("flush_urun", 64'(bus.o_underrun), 64'(1));
    chk("flush_dat", 64'(bus.o_dat), 64'(hold_exp));
    chk("flush_cnt", 64'(bus.o_urun_cnt), 64'(2));

    // reset mid-stream at level 7
    for (int i = 0; i < 7; i++)
      drive(1, mk_frame(16'(i), 16'(i)), 0, 0);
    drive(0, z, 1, 0);
    drive(0, z, 0, 0);
    settle();
    chk("lvl6", 64'(bus.o_level), 64'(6));
    drive(1, mk_frame(16'h7777, 16'h7777), 0, 0);
    settle();
    chk("lvl7", 64'(bus.o_level), 64'(7));
    @(negedge clk);
    bus.i_wr_vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_level", 64'(bus.o_level), 64'(0));
    chk("arst_dat", 64'(bus.o_dat), 64'(0));
    chk("arst_rdy", 64'(bus.o_wr_rdy), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(0, z, 0, 0);
    drive(1, mk_frame(16'hABCD, 16'h1234), 0, 0);
    drive(0, z, 1, 0);
    settle();
    chk("post_rst_dat", 64'(bus.o_dat), 64'(mk_frame(16'hABCD, 16'h1234)));

    // random traffic
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 3) != 0,
            mk_frame(16'($urandom), 16'($urandom)),
            ($urandom % 3) == 0,
            ($urandom % 64) == 0);
    drive(0, z, 0, 0);
    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
